sha256_sched: RTL
=================

SHA256_SCHED -- requirements
Module: sha256_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles in WAIT before the job is aborted (range 1..65535).
REQ-002 SHALL have parameter BEATS, default 8, meaning the 64-bit words per 512-bit message block.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  rising-edge clock; rstb_i  in  1  async active-low reset.
REQ-004 SHALL have: req0_valid  in  1  requester 0 word valid.
REQ-005 SHALL have: req0_data  in  64  requester 0 message word.
REQ-006 SHALL have: req0_ready  out  1  requester 0 word accepted.
REQ-007 SHALL have: req1_valid  in  1; req1_data  in  64; req1_ready  out  1; same meaning for requester 1.
REQ-008 SHALL have: core_start  out  1  one-cycle pulse coincident with the first word of a block.
REQ-009 SHALL have: core_valid  out  1  core_data qualifier.
REQ-010 SHALL have: core_data  out  64  word to the SHA256 core.
REQ-011 SHALL have: core_done  in  1  core digest-valid pulse.
REQ-012 SHALL have: core_digest  in  256  core result.
REQ-013 SHALL have: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1 (granted requester); rsp_digest  out  256.
REQ-014 SHALL have: err_timeout  out  1  one-cycle abort pulse; busy  out  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, LOAD, WAIT, RESP in a registered FSM.
REQ-016 IDLE: if either reqN_valid is high, SHALL latch a grant and enter LOAD next cycle, clearing the beat counter.
REQ-017 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; rr pointer resets to favour requester 0.
REQ-018 The rr pointer SHALL update at grant time, so a lone requester may win repeatedly.
REQ-019 LOAD: reqG_ready SHALL equal reqG_valid (combinational); the non-granted ready SHALL be 0.
REQ-020 LOAD: core_valid SHALL equal reqG_valid and core_data SHALL equal reqG_data.
REQ-021 core_start SHALL be high only on the transfer with beat counter 0.
REQ-022 Gaps (valid low) during LOAD SHALL stall the beat counter, with no timeout applied.
REQ-023 On the BEATS-th transfer the FSM SHALL enter WAIT with the cycle timer cleared.
REQ-024 WAIT: on core_done the FSM SHALL capture core_digest into rsp_digest, set rsp_id to the grant, and enter RESP.
REQ-025 WAIT: otherwise the timer SHALL increment; when it reaches TIMEOUT, err_timeout SHALL pulse one cycle, the FSM SHALL return to IDLE, and no response SHALL be issued.
REQ-026 If core_done coincides with the timeout cycle, core_done SHALL win with no error.
REQ-027 core_done outside WAIT SHALL be ignored.
REQ-028 RESP: rsp_valid SHALL be held high with rsp_id and rsp_digest stable until rsp_ready is sampled high, then the FSM SHALL return to IDLE.
REQ-029 rsp_valid with rsp_ready in the same cycle SHALL complete in that one cycle.
REQ-030 Outside LOAD, both reqN_ready, core_valid and core_start SHALL be 0.
REQ-031 Minimum job latency SHALL be 1 (grant) + BEATS + core latency + 1 cycles from first valid to rsp_valid.

Reset
REQ-032 rstb_i low SHALL asynchronously force: state IDLE, counters 0, rr pointer to requester 0, and all outputs 0 including rsp_digest.
REQ-033 Reset asserted mid-job SHALL abandon the job with no response or error pulse.
REQ-034 Reset deassertion SHALL be synchronised by the user; the FSM SHALL act on the first clock edge after release.

Verification
REQ-035 Req0 only, 8 words 0x8000000030318000 then 7x0, core_done after 64 cycles with digest D -> core_start once on word 0; rsp_valid with rsp_id=0 and rsp_digest=D; busy low after rsp_ready.
REQ-036 Both valid from reset -> grants alternate 0,1,0,1 over four jobs, and the losing ready stays 0 throughout each job.
REQ-037 Valid dropped for 3 cycles after word 4 -> exactly 8 core_valid beats, total LOAD time 11 cycles, no error.
REQ-038 core_done never asserted, TIMEOUT=255 -> err_timeout pulses at WAIT cycle 255, rsp_valid never rises, next request served normally.
REQ-039 rsp_ready held low 20 cycles -> rsp_valid, rsp_id and rsp_digest stay stable, and no new grant occurs.
REQ-040 rstb_i pulsed low during LOAD word 5 -> all outputs 0 immediately, and a fresh job afterwards completes correctly with the grant to requester 0.

Source files
------------

// File: rtl/sha256_sched_if.sv
// Bundles the requester, SHA-256 core and response handshakes of sha256_sched.
// The slave modport is the scheduler's view; master is the surrounding system.
interface sha256_sched_if;
  logic         req0_valid;
  logic [63:0]  req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [63:0]  req1_data;
  logic         req1_ready;
  logic         core_start;
  logic         core_valid;
  logic [63:0]  core_data;
  logic         core_done;
  logic [255:0] core_digest;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [255:0] rsp_digest;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready,
    output core_start, core_valid, core_data,
    input  core_done, core_digest,
    output rsp_valid, rsp_id, rsp_digest,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  core_start, core_valid, core_data,
    output core_done, core_digest,
    input  rsp_valid, rsp_id, rsp_digest,
    output rsp_ready
  );
endinterface

// File: rtl/sha256_sched.sv
// Two-requester round-robin front end: streams one message block into a SHA-256
// core, waits for the digest under a timeout, and hands it back to the winner.
module sha256_sched #(
  parameter int TIMEOUT = 255,
  parameter int BEATS   = 8
) (
  input  logic          clk_i,
  input  logic          rstb_i,
  sha256_sched_if.slave bus,
  output logic          err_timeout,
  output logic          busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  localparam int BEAT_W = $clog2(BEATS + 1);

  logic [1:0]        state;
  logic              grant;
  logic              rr;
  logic [BEAT_W-1:0] beat;
  logic [15:0]       timer;
  logic              rsp_id_q;
  logic [255:0]      digest_q;

  logic        sel_valid;
  logic [63:0] sel_data;
  logic        xfer;
  logic        pick;
  logic        last_beat;
  logic        expire;

  assign sel_valid = grant ? bus.req1_valid : bus.req0_valid;
  assign sel_data  = grant ? bus.req1_data  : bus.req0_data;
  assign xfer      = (state == LOAD) && sel_valid;
  // rr names the requester favoured when both are valid
  assign pick      = (bus.req0_valid && bus.req1_valid) ? rr : bus.req1_valid;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  // a core_done arriving on the final WAIT cycle beats the abort
  assign expire    = (state == WAIT) && !bus.core_done && (timer == 16'(TIMEOUT));

  assign bus.req0_ready = xfer && !grant;
  assign bus.req1_ready = xfer && grant;
  assign bus.core_valid = xfer;
  assign bus.core_start = xfer && (beat == '0);
  assign bus.core_data  = (state == LOAD) ? sel_data : 64'd0;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_digest = digest_q;
  assign err_timeout    = expire;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state    <= IDLE;
      grant    <= 1'b0;
      rr       <= 1'b0;
      beat     <= '0;
      timer    <= 16'd0;
      rsp_id_q <= 1'b0;
      digest_q <= 256'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0_valid || bus.req1_valid) begin
            grant <= pick;
            rr    <= ~pick;
            beat  <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (last_beat) begin
              beat  <= '0;
              timer <= 16'd0;
              state <= WAIT;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        WAIT: begin
          if (bus.core_done) begin
            digest_q <= bus.core_digest;
            rsp_id_q <= grant;
            state    <= RESP;
          end else if (expire) begin
            state <= IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
